// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: one CHUNK-bit slice is resolved per stage and the
// carry ripples register-to-register, giving one result per clock after STAGES clocks.
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             cx;

  // Subtraction is a + ~b + ~borrow; the pipeline itself only ever adds.
  assign bx       = sub ? ~b : b;
  assign cx       = sub ? ~ci : ci;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO  = gi * CHUNK;
      localparam int RW  = LO + CHUNK;
      localparam int REM = WIDTH - RW;

      // Operand bits not yet consumed, with this stage's slice in the low CHUNK bits.
      logic [WIDTH-LO-1:0] a_in;
      logic [WIDTH-LO-1:0] bx_in;
      logic                cin;
      logic [CHUNK:0]      slice_sum;

      logic          valid_q,  valid_d;
      logic          carry_q,  carry_d;
      logic          a_msb_q,  a_msb_d;
      logic          bx_msb_q, bx_msb_d;
      logic [RW-1:0] res_q,    res_d;

      if (gi == 0) begin : g_head
        assign a_in     = a;
        assign bx_in    = bx;
        assign cin      = cx;
        assign valid_d  = in_valid;
        assign a_msb_d  = a[WIDTH-1];
        assign bx_msb_d = bx[WIDTH-1];
        assign res_d    = slice_sum[CHUNK-1:0];
      end else begin : g_body
        assign a_in     = g_stage[gi-1].g_fwd.a_rem_q;
        assign bx_in    = g_stage[gi-1].g_fwd.bx_rem_q;
        assign cin      = g_stage[gi-1].carry_q;
        assign valid_d  = g_stage[gi-1].valid_q;
        assign a_msb_d  = g_stage[gi-1].a_msb_q;
        assign bx_msb_d = g_stage[gi-1].bx_msb_q;
        assign res_d    = {slice_sum[CHUNK-1:0], g_stage[gi-1].res_q};
      end

      assign slice_sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, bx_in[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, cin};
      assign carry_d   = slice_sum[CHUNK];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q  <= 1'b0;
          carry_q  <= 1'b0;
          a_msb_q  <= 1'b0;
          bx_msb_q <= 1'b0;
          res_q    <= '0;
        end else if (adv) begin
          valid_q  <= valid_d;
          carry_q  <= carry_d;
          a_msb_q  <= a_msb_d;
          bx_msb_q <= bx_msb_d;
          res_q    <= res_d;
        end
      end

      if (gi < LAST) begin : g_fwd
        logic [REM-1:0] a_rem_q,  a_rem_d;
        logic [REM-1:0] bx_rem_q, bx_rem_d;

        assign a_rem_d  = a_in[WIDTH-LO-1:CHUNK];
        assign bx_rem_d = bx_in[WIDTH-LO-1:CHUNK];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_rem_q  <= '0;
            bx_rem_q <= '0;
          end else if (adv) begin
            a_rem_q  <= a_rem_d;
            bx_rem_q <= bx_rem_d;
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[LAST].valid_q;
  assign s         = g_stage[LAST].res_q;
  assign co        = g_stage[LAST].carry_q;
  assign ovf       = (g_stage[LAST].a_msb_q == g_stage[LAST].bx_msb_q)
                  && (s[WIDTH-1] != g_stage[LAST].a_msb_q);

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, CHUNK=4): directed corner cases,
// stall/back-pressure, mid-stream reset and a randomized scoreboard run.
module tb_pipe_adder;

  localparam int W   = 16;
  localparam int C   = 4;
  localparam int LAT = W / C;
  localparam int N_RANDOM = 10000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ci = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    int           acc_cyc;
    int           stalls;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [W-1:0] TA   [5] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
  localparam logic [W-1:0] TB   [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
  localparam logic         TCI  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic         TSUB [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [W-1:0] TS   [5] = '{16'h0100, 16'h0001, 16'h8000, 16'hFFFE, 16'h7FFF};
  localparam logic         TCO  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic         TOVF [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  pipe_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: {ovf, co, s} from plain (W+1)-bit arithmetic on the effective operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic civ, input logic subv);
    logic [W-1:0] bxv;
    logic         cxv;
    logic [W:0]   sum;
    logic         ov;
    bxv = subv ? ~bv : bv;
    cxv = subv ? ~civ : civ;
    sum = {1'b0, av} + {1'b0, bxv} + {{W{1'b0}}, cxv};
    ov  = (av[W-1] == bxv[W-1]) && (sum[W-1] != av[W-1]);
    return {ov, sum};
  endfunction

  function automatic exp_t make_exp(input int cyc, input int stalls);
    logic [W+1:0] m;
    exp_t e;
    m = model(a, b, ci, sub);
    e.s = m[W-1:0];
    e.co = m[W];
    e.ovf = m[W+1];
    e.acc_cyc = cyc;
    e.stalls = stalls;
    return e;
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, co, ovf, s, in_ready} !== {3'b000, {W{1'b0}}, 1'b1})
      $display("FAIL reset_state: got out_valid=%b s=%h co=%b ovf=%b in_ready=%b, want 0 0000 0 0 1",
               out_valid, s, co, ovf, in_ready);
    else
      n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: out_valid=%b s=%h in_ready=%b", out_valid, s, in_ready);
  endtask

  task automatic test_directed();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = TA[i]; b = TB[i]; ci = TCI[i]; sub = TSUB[i];
      in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (k == LAT - 1) begin
          n_checks++;
          if (out_valid !== 1'b0)
            $display("FAIL directed%0d_early: out_valid=%b at %0d clocks, want 0", i, out_valid, k);
          else
            n_pass++;
        end
      end
      n_checks++;
      if ({out_valid, s, co, ovf} !== {1'b1, TS[i], TCO[i], TOVF[i]})
        $display("FAIL directed%0d: got v=%b s=%h co=%b ovf=%b, want v=1 s=%h co=%b ovf=%b",
                 i, out_valid, s, co, ovf, TS[i], TCO[i], TOVF[i]);
      else
        n_pass++;
      $display("directed%0d: a=%h b=%h ci=%b sub=%b -> s=%h co=%b ovf=%b",
               i, TA[i], TB[i], TCI[i], TSUB[i], s, co, ovf);
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   got = 0;
    exp_t e;
    exp_q.delete();
    for (int cyc = 1; cyc <= 40 && got < 8; cyc++) begin
      @(negedge clk);
      in_valid = (sent < 8);
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      out_ready = !(cyc >= 6 && cyc <= 8);
      #1;
      if (cyc >= 6 && cyc <= 8) begin
        n_checks++;
        if (in_ready !== 1'b0)
          $display("FAIL b2b_stall_ready: cycle %0d in_ready=%b, want 0", cyc, in_ready);
        else
          n_pass++;
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_extra: unexpected result s=%h at cycle %0d, want none", s, cyc);
        end else begin
          e = exp_q[0];
          if ({s, co, ovf} !== {e.s, e.co, e.ovf})
            $display("FAIL b2b_data: cycle %0d got s=%h co=%b ovf=%b, want s=%h co=%b ovf=%b",
                     cyc, s, co, ovf, e.s, e.co, e.ovf);
          else
            n_pass++;
          if (out_ready) begin
            void'(exp_q.pop_front());
            got++;
            $display("b2b: result %0d s=%h co=%b ovf=%b at cycle %0d", got, s, co, ovf, cyc);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(make_exp(cyc, 0));
        sent++;
      end
    end
    n_checks++;
    if (got != 8 || exp_q.size() != 0)
      $display("FAIL b2b_count: got %0d results with %0d pending, want 8 and 0", got, exp_q.size());
    else
      n_pass++;
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      a = W'($urandom) | 16'h0101; b = W'($urandom); ci = 1'b1; sub = 1'b0;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, s, co, ovf} !== {1'b0, {W{1'b0}}, 2'b00})
      $display("FAIL midreset_outputs: got v=%b s=%h co=%b ovf=%b, want 0 0000 0 0",
               out_valid, s, co, ovf);
    else
      n_pass++;
    n_checks++;
    if (in_ready !== 1'b1)
      $display("FAIL midreset_in_ready: in_ready=%b, want 1", in_ready);
    else
      n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 2 * LAT; k++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b0)
        $display("FAIL midreset_ghost: out_valid=%b %0d cycles after release, want 0", out_valid, k);
      else
        n_pass++;
      @(negedge clk);
    end
    $display("midreset: no results emitted after release");
  endtask

  task automatic test_random();
    int   cyc = 0;
    int   stalls = 0;
    int   acc = 0;
    int   emitted = 0;
    exp_t e;
    exp_q.delete();
    while (cyc < 60000) begin
      @(negedge clk);
      if (acc < N_RANDOM) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      if ($urandom_range(0, 7) == 0) a = 16'h7FFF;
      if ($urandom_range(0, 7) == 0) b = 16'h8000;
      #1;
      n_checks++;
      if (in_ready !== (!out_valid || out_ready))
        $display("FAIL rand_in_ready: cycle %0d in_ready=%b, want %b", cyc, in_ready,
                 !out_valid || out_ready);
      else
        n_pass++;
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_extra: unexpected result s=%h at cycle %0d, want none", s, cyc);
        end else begin
          e = exp_q[0];
          if ({s, co, ovf} !== {e.s, e.co, e.ovf})
            $display("FAIL rand_data: cycle %0d got s=%h co=%b ovf=%b, want s=%h co=%b ovf=%b",
                     cyc, s, co, ovf, e.s, e.co, e.ovf);
          else
            n_pass++;
          if (out_ready) begin
            if (e.stalls == stalls) begin
              n_checks++;
              if (cyc - e.acc_cyc != LAT)
                $display("FAIL rand_latency: got %0d clocks, want %0d", cyc - e.acc_cyc, LAT);
              else
                n_pass++;
            end
            void'(exp_q.pop_front());
            emitted++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(make_exp(cyc, stalls));
        acc++;
      end
      if (out_valid && !out_ready) stalls++;
      cyc++;
      if (acc >= N_RANDOM && exp_q.size() == 0) break;
    end
    n_checks++;
    if (acc != N_RANDOM || emitted != N_RANDOM || exp_q.size() != 0)
      $display("FAIL rand_complete: accepted %0d emitted %0d pending %0d, want %0d %0d 0",
               acc, emitted, exp_q.size(), N_RANDOM, N_RANDOM);
    else
      n_pass++;
    $display("random: %0d ops accepted, %0d emitted in %0d cycles, %0d stall cycles",
             acc, emitted, cyc, stalls);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
